// File: rtl/alu_dec_result_stage.sv
// rtl/alu_dec_result_stage.sv - registered ALU result stage with BCD correction and status register P
module alu_dec_result_stage #(
  parameter logic DEC_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_valid,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  input  logic       alu_carry,
  input  logic       alu_half_carry,
  input  logic       dec_add,
  input  logic       dec_sub,
  input  logic [3:0] flag_we,
  input  logic       p_load,
  input  logic [7:0] p_in,
  input  logic [7:0] p_set_mask,
  input  logic [7:0] p_clr_mask,
  output logic       busy,
  output logic       res_valid,
  output logic [7:0] res_out,
  output logic [7:0] p_out,
  output logic       decimal
);

  typedef enum logic {IDLE, ADJ} state_t;

  state_t     state, state_nxt;
  logic [7:0] cap_out;
  logic [3:0] cap_flags;
  logic       cap_carry, cap_half_carry, cap_add, cap_sub;
  logic [3:0] cap_we;

  logic       dec_req;
  logic       capture;
  logic       res_valid_nxt;
  logic [7:0] res_out_nxt;
  logic [7:0] wr_mask, wr_val;
  logic [7:0] p_nxt;

  // Per-nibble BCD fixup; the sum wraps mod 16 with no carry into the other nibble.
  function automatic logic [3:0] nib_adj(input logic [3:0] n, input logic add,
                                         input logic sub, input logic c);
    logic [3:0] corr;
    corr = (add && c) ? 4'h6 : ((sub && !c) ? 4'hA : 4'h0);
    return n + corr;
  endfunction

  assign dec_req = DEC_ENABLE && (dec_add || dec_sub);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (alu_valid && dec_req) state_nxt = ADJ;
      ADJ:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture       = 1'b0;
    res_valid_nxt = 1'b0;
    res_out_nxt   = res_out;
    wr_mask       = 8'h00;
    wr_val        = 8'h00;
    case (state)
      IDLE: begin
        if (alu_valid && dec_req) begin
          capture = 1'b1;
        end else if (alu_valid) begin
          res_valid_nxt = 1'b1;
          res_out_nxt   = alu_out;
          wr_mask       = {flag_we[3:2], 4'b0000, flag_we[1:0]};
          wr_val        = {alu_flags[3:2], 4'b0000, alu_flags[1:0]};
        end
      end
      ADJ: begin
        res_valid_nxt = 1'b1;
        res_out_nxt   = {nib_adj(cap_out[7:4], cap_add, cap_sub, cap_carry),
                         nib_adj(cap_out[3:0], cap_add, cap_sub, cap_half_carry)};
        // N/V/Z reflect the binary result; C is the decimal-aware adder carry.
        wr_mask       = {cap_we[3:2], 4'b0000, cap_we[1:0]};
        wr_val        = {cap_flags[3:2], 4'b0000, cap_flags[1], cap_carry};
      end
      default: ;
    endcase

    for (int i = 0; i < 8; i++) begin
      if (p_load)             p_nxt[i] = p_in[i];
      else if (p_set_mask[i]) p_nxt[i] = 1'b1;
      else if (p_clr_mask[i]) p_nxt[i] = 1'b0;
      else if (wr_mask[i])    p_nxt[i] = wr_val[i];
      else                    p_nxt[i] = p_out[i];
    end
    p_nxt[5:4] = 2'b11;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid      <= 1'b0;
      res_out        <= 8'h00;
      p_out          <= 8'h34;
      cap_out        <= 8'h00;
      cap_flags      <= 4'h0;
      cap_carry      <= 1'b0;
      cap_half_carry <= 1'b0;
      cap_add        <= 1'b0;
      cap_sub        <= 1'b0;
      cap_we         <= 4'h0;
    end else begin
      res_valid <= res_valid_nxt;
      res_out   <= res_out_nxt;
      p_out     <= p_nxt;
      if (capture) begin
        cap_out        <= alu_out;
        cap_flags      <= alu_flags;
        cap_carry      <= alu_carry;
        cap_half_carry <= alu_half_carry;
        cap_add        <= dec_add;
        cap_sub        <= dec_sub;
        cap_we         <= flag_we;
      end
    end
  end

  assign busy    = (state == ADJ);
  assign decimal = p_out[3];

endmodule

// File: tb/tb_alu_dec_result_stage.sv
// tb/tb_alu_dec_result_stage.sv - directed self-checking bench for alu_dec_result_stage
module tb_alu_dec_result_stage;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_valid;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic       alu_carry, alu_half_carry, dec_add, dec_sub;
  logic [3:0] flag_we;
  logic       p_load;
  logic [7:0] p_in, p_set_mask, p_clr_mask;
  logic       busy, res_valid, decimal;
  logic [7:0] res_out, p_out;

  int n_cmp = 0;
  int n_fail = 0;

  alu_dec_result_stage dut (
    .clk(clk), .reset_n(reset_n), .alu_valid(alu_valid), .alu_out(alu_out),
    .alu_flags(alu_flags), .alu_carry(alu_carry), .alu_half_carry(alu_half_carry),
    .dec_add(dec_add), .dec_sub(dec_sub), .flag_we(flag_we), .p_load(p_load),
    .p_in(p_in), .p_set_mask(p_set_mask), .p_clr_mask(p_clr_mask), .busy(busy),
    .res_valid(res_valid), .res_out(res_out), .p_out(p_out), .decimal(decimal)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_valid = 0; alu_out = 8'h00; alu_flags = 4'h0; alu_carry = 0; alu_half_carry = 0;
    dec_add = 0; dec_sub = 0; flag_we = 4'h0; p_load = 0; p_in = 8'h00;
    p_set_mask = 8'h00; p_clr_mask = 8'h00;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0; idle_inputs();
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %h want 0", res_valid); end
    n_cmp++; if (res_out !== 8'h00) begin n_fail++; $display("FAIL reset_res_out got %h want 00", res_out); end
    n_cmp++; if (p_out !== 8'h34) begin n_fail++; $display("FAIL reset_p_out got %h want 34", p_out); end
    n_cmp++; if (decimal !== 1'b0) begin n_fail++; $display("FAIL reset_decimal got %h want 0", decimal); end
    reset_n = 1;
    step();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_res_valid got %h want 0", res_valid); end
  endtask

  task automatic test_binary();
    alu_valid = 1; alu_out = 8'h80; alu_flags = 4'b1100; flag_we = 4'b1111;
    step(); idle_inputs();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bin_res_valid got %h want 1", res_valid); end
    n_cmp++; if (res_out !== 8'h80) begin n_fail++; $display("FAIL bin_res_out got %h want 80", res_out); end
    n_cmp++; if (p_out !== 8'hF4) begin n_fail++; $display("FAIL bin_p_out got %h want F4", p_out); end
    step();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bin_pulse_end got %h want 0", res_valid); end
    n_cmp++; if (res_out !== 8'h80) begin n_fail++; $display("FAIL bin_hold got %h want 80", res_out); end
  endtask

  task automatic test_decimal_add();
    alu_valid = 1; alu_out = 8'h41; alu_half_carry = 1; alu_carry = 0; dec_add = 1; flag_we = 4'b0001;
    step(); idle_inputs();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dadd_busy got %h want 1", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL dadd_early_valid got %h want 0", res_valid); end
    step();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL dadd_res_valid got %h want 1", res_valid); end
    n_cmp++; if (res_out !== 8'h47) begin n_fail++; $display("FAIL dadd_res_out got %h want 47", res_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dadd_busy_clear got %h want 0", busy); end
    n_cmp++; if (p_out !== 8'hF4) begin n_fail++; $display("FAIL dadd_p_out got %h want F4", p_out); end
  endtask

  task automatic test_decimal_sub();
    alu_valid = 1; alu_out = 8'h2D; alu_half_carry = 0; alu_carry = 1; dec_sub = 1;
    alu_flags = 4'b0000; flag_we = 4'b1111;
    step(); idle_inputs();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dsub_busy got %h want 1", busy); end
    step();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL dsub_res_valid got %h want 1", res_valid); end
    n_cmp++; if (res_out !== 8'h27) begin n_fail++; $display("FAIL dsub_res_out got %h want 27", res_out); end
    n_cmp++; if (p_out !== 8'h35) begin n_fail++; $display("FAIL dsub_p_out got %h want 35", p_out); end
  endtask

  task automatic test_priority();
    alu_valid = 1; alu_out = 8'h11; alu_flags = 4'b1111; flag_we = 4'b1111; p_load = 1; p_in = 8'h00;
    step(); idle_inputs();
    n_cmp++; if (p_out !== 8'h30) begin n_fail++; $display("FAIL prio_load got %h want 30", p_out); end
    n_cmp++; if (res_out !== 8'h11) begin n_fail++; $display("FAIL prio_res_out got %h want 11", res_out); end
    p_set_mask = 8'h08; p_clr_mask = 8'h08;
    step(); idle_inputs();
    n_cmp++; if (p_out !== 8'h38) begin n_fail++; $display("FAIL prio_set_clr got %h want 38", p_out); end
    n_cmp++; if (decimal !== 1'b1) begin n_fail++; $display("FAIL prio_decimal got %h want 1", decimal); end
  endtask

  task automatic test_busy_drop();
    int pulses;
    pulses = 0;
    alu_valid = 1; alu_out = 8'h41; alu_half_carry = 1; alu_carry = 0; dec_add = 1; flag_we = 4'b0001;
    step(); idle_inputs();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy got %h want 1", busy); end
    alu_valid = 1; alu_out = 8'h55; flag_we = 4'b1111; alu_flags = 4'b1111; p_set_mask = 8'h01;
    step(); idle_inputs();
    if (res_valid === 1'b1) pulses++;
    n_cmp++; if (res_out !== 8'h47) begin n_fail++; $display("FAIL drop_res_out got %h want 47", res_out); end
    n_cmp++; if (p_out !== 8'h39) begin n_fail++; $display("FAIL drop_p_out got %h want 39", p_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      if (res_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL drop_pulses got %0d want 1", pulses); end
    n_cmp++; if (res_out !== 8'h47) begin n_fail++; $display("FAIL drop_hold got %h want 47", res_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got %h want 0", busy); end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1; alu_out = 8'hA5; flag_we = 4'b0000;
    step();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %h want 1", res_valid); end
    n_cmp++; if (res_out !== 8'hA5) begin n_fail++; $display("FAIL b2b_first_out got %h want A5", res_out); end
    alu_valid = 1; alu_out = 8'h5A; alu_flags = 4'b0010; flag_we = 4'b0010;
    step(); idle_inputs();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %h want 1", res_valid); end
    n_cmp++; if (res_out !== 8'h5A) begin n_fail++; $display("FAIL b2b_second_out got %h want 5A", res_out); end
    n_cmp++; if (p_out !== 8'h3B) begin n_fail++; $display("FAIL b2b_p_out got %h want 3B", p_out); end
  endtask

  task automatic test_reset_mid_adj();
    alu_valid = 1; alu_out = 8'h41; alu_half_carry = 1; alu_carry = 0; dec_add = 1; flag_we = 4'b1111;
    step(); idle_inputs();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_adj_busy got %h want 1", busy); end
    reset_n = 0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_adj_busy_clr got %h want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_adj_valid got %h want 0", res_valid); end
    n_cmp++; if (res_out !== 8'h00) begin n_fail++; $display("FAIL rst_adj_res_out got %h want 00", res_out); end
    n_cmp++; if (p_out !== 8'h34) begin n_fail++; $display("FAIL rst_adj_p_out got %h want 34", p_out); end
    #2 reset_n = 1;
    step();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_adj_no_result got %h want 0", res_valid); end
    n_cmp++; if (res_out !== 8'h00) begin n_fail++; $display("FAIL rst_adj_out_after got %h want 00", res_out); end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_decimal_add();
    test_decimal_sub();
    test_priority();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid_adj();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
